// File: rtl/mul8_shift_add.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// The add itself is done by an external combinational adder driven through the adder_* ports.
module mul8_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   adder_operand1,
  output logic [WIDTH-1:0]   adder_operand2,
  output logic               adder_carry_in,
  input  logic [WIDTH-1:0]   adder_result,
  input  logic               adder_carry_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   m_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] product_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   a_next_s;
  logic [WIDTH-1:0]   q_next_s;

  // Carry-out is kept as the top bit so a full-scale step cannot overflow A.
  assign sum_s    = {adder_carry_out, adder_result};
  assign a_next_s = sum_s[WIDTH:1];
  assign q_next_s = {sum_s[0], q_r[WIDTH-1:1]};

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_STEP) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Adder drive: operands only presented while stepping, otherwise quiet.
  always_comb begin
    adder_operand1 = {WIDTH{1'b0}};
    adder_operand2 = {WIDTH{1'b0}};
    adder_carry_in = 1'b0;
    if (state_r == CALC) begin
      adder_operand1 = a_r;
      adder_operand2 = q_r[0] ? m_r : {WIDTH{1'b0}};
    end else begin
      adder_operand1 = {WIDTH{1'b0}};
      adder_operand2 = {WIDTH{1'b0}};
    end
  end

  // Operand capture, per-step shift/accumulate and product latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      m_r       <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            m_r   <= multiplicand;
            q_r   <= multiplier;
            a_r   <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        CALC: begin
          a_r   <= a_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_STEP) begin
            product_r <= {a_next_s, q_next_s};
          end else begin
            product_r <= product_r;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == CALC);
      done_r <= (state_s == DONE);
    end
  end

endmodule
